// File: rtl/ifu_fetch.sv
// ifu_fetch: one-outstanding-request instruction fetch unit.
// Optional IFU_MISALIGN_CHECK_EN traps pc[1:0] != 0 without a memory access.
module ifu_fetch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  output logic             pc_wen,
  input  logic             flush,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [31:0]      req_addr,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [31:0]      resp_data,
  input  logic             resp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_err,
  output logic             inst_misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      inst_q;
  logic [31:0]      inst_pc_q;
  logic             inst_err_q;
  logic             drop_q, drop_nxt;
  logic [CNT_W-1:0] cnt_q;

  logic hs_req;
  logic cap_resp;
  logic cap_mis;
  logic mis;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_q;
  assign mis = (pc[1:0] != 2'b00);
  assign inst_misalign = mis_q;
`else
  assign mis = 1'b0;
  assign inst_misalign = 1'b0;
`endif

  assign req_addr  = pc;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign inst_err  = inst_err_q;
  assign fetch_cnt = cnt_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // next state, handshake outputs and capture strobes
  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop_q;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    inst_valid = 1'b0;
    pc_wen     = 1'b0;
    hs_req     = 1'b0;
    cap_resp   = 1'b0;
    cap_mis    = 1'b0;
    if (!rst) begin
      unique case (state)
        REQ: begin
          if (!flush && mis) begin
            cap_mis   = 1'b1;
            state_nxt = HOLD;
          end else begin
            req_valid = !flush;
            if (!flush && req_ready) begin
              hs_req    = 1'b1;
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          resp_ready = 1'b1;
          if (resp_valid) begin
            if (drop_q || flush) begin
              drop_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              cap_resp  = 1'b1;
              state_nxt = HOLD;
            end
          end else if (flush) begin
            drop_nxt = 1'b1;
          end
        end
        HOLD: begin
          inst_valid = 1'b1;
          if (flush) begin
            state_nxt = REQ;
          end else if (inst_ready) begin
            pc_wen    = 1'b1;
            state_nxt = REQ;
          end
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  // fetched instruction, its pc/fault, drop flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      drop_q <= drop_nxt;
      if (hs_req) inst_pc_q <= pc;
      if (cap_resp) begin
        inst_q     <= resp_data;
        inst_err_q <= resp_err;
      end
      if (cap_mis) begin
        inst_q     <= '0;
        inst_pc_q  <= pc;
        inst_err_q <= 1'b1;
      end
      if (pc_wen) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // misalign flag follows the most recent capture
  always_ff @(posedge clk) begin
    if (rst)          mis_q <= 1'b0;
    else if (cap_mis) mis_q <= 1'b1;
    else if (cap_resp) mis_q <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: cycle vector table plus directed
// sequences for counter wrap and pc misalignment.
module tb_ifu_fetch;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc;
  logic          pc_wen;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_err;
  logic          inst_misalign;
  logic [CW-1:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt;

  ifu_fetch #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_misalign(inst_misalign), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rq;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        fl;
    logic        ir;
    logic        e_reqv;
    logic        e_respr;
    logic        e_iv;
    logic        e_wen;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_err;
    int          e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(
    input logic r, input logic [31:0] p, input logic rq, input logic rv,
    input logic [31:0] rd, input logic re, input logic fl, input logic ir,
    input logic ereqv, input logic erespr, input logic eiv, input logic ewen,
    input logic [31:0] einst, input logic [31:0] eipc, input logic eerr,
    input int ecnt);
    vec_t v;
    v.rst = r; v.pc = p; v.rq = rq; v.rv = rv; v.rd = rd; v.re = re;
    v.fl = fl; v.ir = ir; v.e_reqv = ereqv; v.e_respr = erespr;
    v.e_iv = eiv; v.e_wen = ewen; v.e_inst = einst; v.e_ipc = eipc;
    v.e_err = eerr; v.e_cnt = ecnt;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    resp_err = 1'b0; flush = 1'b0; inst_ready = 1'b0;
  endtask

  // zero-wait fetch of d from address a, then accept
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      pc = a; req_ready = 1'b1; resp_valid = 1'b1;
      resp_data = d; resp_err = 1'b0; flush = 1'b0; inst_ready = 1'b1;
      #1;
      if (pc_wen) begin
        done = 1;
        chk("fetch inst", inst, d);
        chk("fetch inst_pc", inst_pc, a);
        chk("fetch inst_err", 32'(inst_err), 32'd0);
        chk("fetch misalign", 32'(inst_misalign), 32'd0);
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch timeout: got no pc_wen expected pc_wen at %h", a);
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    @(negedge clk);
    idle();
    #1;
    chk("fetch cnt", 32'(fetch_cnt), 32'(exp_cnt));
    chk("fetch no 2nd wen", 32'(pc_wen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p0, p4, p8, p10, p14, p20, p24, dbf;
    p0 = 32'h8000_0000; p4 = 32'h8000_0004; p8 = 32'h8000_0008;
    p10 = 32'h8000_0010; p14 = 32'h8000_0014; p20 = 32'h8000_0020;
    p24 = 32'h8000_0024; dbf = 32'hDEAD_BEEF;

    // basic zero-wait fetch
    add(1,p0,1,0,0,0,0,1, 0,0,0,0, 0,0,0,0);
    add(0,p0,1,0,0,0,0,1, 1,0,0,0, 0,0,0,0);
    add(0,p0,0,1,32'h413,0,0,1, 0,1,0,0, 0,p0,0,0);
    add(0,p0,0,0,0,0,0,1, 0,0,1,1, 32'h413,p0,0,0);
    // req_ready low 4 cycles, response 3 cycles late
    for (int i = 0; i < 4; i++)
      add(0,p4,0,0,0,0,0,1, 1,0,0,0, 32'h413,p0,0,1);
    add(0,p4,1,0,0,0,0,1, 1,0,0,0, 32'h413,p0,0,1);
    for (int i = 0; i < 3; i++)
      add(0,p4,0,0,0,0,0,1, 0,1,0,0, 32'h413,p4,0,1);
    add(0,p4,0,1,32'h13,0,0,1, 0,1,0,0, 32'h413,p4,0,1);
    // decode stall 5 cycles
    for (int i = 0; i < 5; i++)
      add(0,p4,1,0,0,0,0,0, 0,0,1,0, 32'h13,p4,0,1);
    add(0,p4,0,0,0,0,0,1, 0,0,1,1, 32'h13,p4,0,1);
    // flush in WAIT, late response dropped
    add(0,p8,1,0,0,0,0,1, 1,0,0,0, 32'h13,p4,0,2);
    add(0,p8,0,0,0,0,1,1, 0,1,0,0, 32'h13,p8,0,2);
    add(0,p8,0,0,0,0,0,1, 0,1,0,0, 32'h13,p8,0,2);
    add(0,p8,0,1,dbf,0,0,1, 0,1,0,0, 32'h13,p8,0,2);
    // access fault response
    add(0,p10,1,0,0,0,0,1, 1,0,0,0, 32'h13,p8,0,2);
    add(0,p10,0,1,0,1,0,1, 0,1,0,0, 32'h13,p10,0,2);
    add(0,p10,0,0,0,0,0,1, 0,0,1,1, 0,p10,1,2);
    // next fetch clears the fault, then flush in HOLD
    add(0,p14,1,0,0,0,0,1, 1,0,0,0, 0,p10,1,3);
    add(0,p14,0,1,32'h93,0,0,0, 0,1,0,0, 0,p14,1,3);
    add(0,p14,0,0,0,0,1,1, 0,0,1,0, 32'h93,p14,0,3);
    // flush in REQ, then flush coinciding with response
    add(0,p20,1,0,0,0,1,0, 0,0,0,0, 32'h93,p14,0,3);
    add(0,p20,1,0,0,0,0,0, 1,0,0,0, 32'h93,p14,0,3);
    add(0,p20,0,1,dbf,0,1,0, 0,1,0,0, 32'h93,p20,0,3);
    add(0,p24,0,0,0,0,0,0, 1,0,0,0, 32'h93,p20,0,3);
    // reset mid-transaction, late response ignored
    add(0,p24,1,0,0,0,0,0, 1,0,0,0, 32'h93,p20,0,3);
    add(1,p24,0,0,0,0,0,0, 0,0,0,0, 32'h93,p24,0,3);
    add(0,p0,0,1,dbf,0,0,0, 1,0,0,0, 0,0,0,0);
    add(0,p0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0);

    rst = 1'b1; pc = p0; idle();
    repeat (3) @(negedge clk);

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; pc = tv[i].pc; req_ready = tv[i].rq;
      resp_valid = tv[i].rv; resp_data = tv[i].rd; resp_err = tv[i].re;
      flush = tv[i].fl; inst_ready = tv[i].ir;
      #1;
      chk($sformatf("v%0d req_valid", i), 32'(req_valid), 32'(tv[i].e_reqv));
      chk($sformatf("v%0d resp_ready", i), 32'(resp_ready), 32'(tv[i].e_respr));
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(tv[i].e_iv));
      chk($sformatf("v%0d pc_wen", i), 32'(pc_wen), 32'(tv[i].e_wen));
      chk($sformatf("v%0d inst", i), inst, tv[i].e_inst);
      chk($sformatf("v%0d inst_pc", i), inst_pc, tv[i].e_ipc);
      chk($sformatf("v%0d inst_err", i), 32'(inst_err), 32'(tv[i].e_err));
      chk($sformatf("v%0d fetch_cnt", i), 32'(fetch_cnt), 32'(tv[i].e_cnt));
      if (tv[i].e_reqv)
        chk($sformatf("v%0d req_addr", i), req_addr, tv[i].pc);
    end

    // counter wraps modulo 2^CW
    exp_cnt = 0;
    for (int i = 0; i < 9; i++)
      do_fetch(32'h8000_1000 + 32'(i * 4), 32'h0010_0013 + 32'(i));

    // misaligned pc
`ifdef IFU_MISALIGN_CHECK_EN
    @(negedge clk);
    pc = 32'h8000_0002; req_ready = 1'b1;
    #1;
    chk("mis req_valid", 32'(req_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("mis inst_valid", 32'(inst_valid), 32'd1);
    chk("mis inst", inst, 32'd0);
    chk("mis inst_pc", inst_pc, 32'h8000_0002);
    chk("mis inst_err", 32'(inst_err), 32'd1);
    chk("mis flag", 32'(inst_misalign), 32'd1);
    chk("mis req_valid hold", 32'(req_valid), 32'd0);
    @(negedge clk);
    inst_ready = 1'b1;
    #1;
    chk("mis pc_wen", 32'(pc_wen), 32'd1);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    @(negedge clk);
    idle();
    #1;
    chk("mis cnt", 32'(fetch_cnt), 32'(exp_cnt));
    do_fetch(32'h8000_0004, 32'h0000_0013);
`else
    @(negedge clk);
    pc = 32'h8000_0002; req_ready = 1'b1;
    #1;
    chk("mis req_valid", 32'(req_valid), 32'd1);
    chk("mis req_addr", req_addr, 32'h8000_0002);
    chk("mis flag", 32'(inst_misalign), 32'd0);
    do_fetch(32'h8000_0002, 32'h0000_0013);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
